led_bank_arbiter: RTL and testbench

Time-sliced round-robin arbiter sharing the board's 6-LED bank between up to N_REQ pattern sources (counters, status displays, debug). An internal prescaler generates a slow tick. Each granted requester owns the bank for SLICE_TICKS ticks before ownership rotates to the next pending requester. Sits between the pattern-generating blocks and the active-low LED pins.

---
 rtl/led_bank_arbiter.sv | 103 ++++++++++
 tb/tb_led_bank_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Time-sliced round-robin owner selection for a shared LED bank.
// A free-running prescaler paces the slices; led_o drives active-low pins.
module led_bank_arbiter #(
  parameter int N_REQ       = 4,
  parameter int LED_W       = 6,
  parameter int TICK_COUNT  = 13500000,
  parameter int SLICE_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*LED_W-1:0]   pattern_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic                     busy_o,
  output logic                     tick_o,
  output logic [LED_W-1:0]         led_o
);
  localparam int PW = $clog2(TICK_COUNT);
  localparam int SW = $clog2(SLICE_TICKS + 1);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ARB, OWN} state_t;

  state_t          state;
  logic [PW-1:0]   pre_cnt;
  logic [SW-1:0]   slice_cnt;
  logic [IW-1:0]   ptr, owner;
  logic [IW-1:0]   win_idx;
  logic            win_vld;
  logic            others;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                pre_cnt <= '0;
    else if (pre_cnt == PW'(TICK_COUNT - 1)) pre_cnt <= '0;
    else                                    pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick_o = (pre_cnt == PW'(TICK_COUNT - 1));

  // Scan from the far end back toward ptr so the closest pending index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr) + i) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  assign others = |(req_i & ~(N_REQ'(1) << owner));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_o     <= '0;
      busy_o    <= 1'b0;
      ptr       <= '0;
      owner     <= '0;
      slice_cnt <= '0;
      led_o     <= '1;
    end else begin
      led_o <= (state == OWN) ? ~pattern_i[int'(owner)*LED_W +: LED_W] : '1;
      case (state)
        IDLE: if (|req_i) state <= ARB;
        ARB: begin
          if (win_vld) begin
            gnt_o     <= N_REQ'(1) << win_idx;
            busy_o    <= 1'b1;
            owner     <= win_idx;
            ptr       <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
            slice_cnt <= '0;
            state     <= OWN;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          // Release outranks slice expiry.
          if (!req_i[owner]) begin
            gnt_o  <= '0;
            busy_o <= 1'b0;
            state  <= ARB;
          end else if (tick_o) begin
            if (slice_cnt == SW'(SLICE_TICKS - 1)) begin
              if (others) begin
                gnt_o  <= '0;
                busy_o <= 1'b0;
                state  <= ARB;
              end else begin
                slice_cnt <= '0;
              end
            end else begin
              slice_cnt <= slice_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Randomized and directed check of led_bank_arbiter against a cycle-level
// reference model that tracks owner, pending arbitration and ticks as integers.
module tb_led_bank_arbiter;
  localparam int N  = 4;
  localparam int W  = 6;
  localparam int TC = 4;
  localparam int ST = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   pattern;
  logic [N-1:0]     gnt;
  logic             busy, tick;
  logic [W-1:0]     led;

  int n_chk = 0;
  int n_fail = 0;

  // Model: m_own = -1 means nobody holds the bank.
  int       m_own, m_ptr, m_slice, m_n;
  bit       m_arb;
  logic [W-1:0] m_led;

  led_bank_arbiter #(.N_REQ(N), .LED_W(W), .TICK_COUNT(TC), .SLICE_TICKS(ST)) dut (
    .clk(clk), .rst(rst), .req_i(req), .pattern_i(pattern),
    .gnt_o(gnt), .busy_o(busy), .tick_o(tick), .led_o(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_slice = 0; m_n = 0; m_arb = 0; m_led = '1;
  endtask

  task automatic model_step();
    bit tk;
    bit found;
    tk = (m_n % TC == TC - 1);
    m_n++;
    m_led = (m_own >= 0) ? ~pattern[m_own*W +: W] : '1;
    if (m_arb) begin
      m_arb = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && req[idx]) begin
          found = 1; m_own = idx; m_ptr = (idx + 1) % N; m_slice = 0;
        end
      end
    end else if (m_own < 0) begin
      m_arb = (req != 0);
    end else if (!req[m_own]) begin
      m_own = -1; m_arb = 1;
    end else if (tk) begin
      if (m_slice == ST - 1) begin
        if ((req & ~(N'(1) << m_own)) != 0) begin
          m_own = -1; m_arb = 1;
        end else m_slice = 0;
      end else m_slice++;
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check("gnt",  gnt,  (m_own >= 0) ? (N'(1) << m_own) : '0);
    check("busy", busy, m_own >= 0);
    check("tick", tick, (m_n % TC) == TC - 1);
    check("led",  led,  m_led);
  endtask

  initial begin
    rst = 1'b1; req = '0; pattern = '0;
    model_reset();
    repeat (3) cyc();
    check("rst_led", led, 6'b111111);
    rst = 1'b0;
    repeat (9) cyc();

    // Single requester keeps the bank across expiries.
    req = 4'b0100;
    pattern[2*W +: W] = 6'b000011;
    repeat (20) cyc();
    check("single_gnt", gnt, 4'b0100);
    check("single_led", led, 6'b111100);

    // Round-robin rotation with constant requests.
    req = 4'b1011;
    repeat (40) begin pattern = 24'($urandom); cyc(); end

    // Early release by owner 0 with requester 3 pending.
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 4'b1001; pattern = 24'($urandom);
    repeat (5) cyc();
    check("early_own", gnt, 4'b0001);
    req = 4'b1000;
    cyc();
    check("early_gap", gnt, 4'b0000);
    cyc();
    check("early_next", gnt, 4'b1000);
    check("early_dark", led, 6'b111111);
    repeat (4) cyc();

    // Asynchronous reset pulse between edges while a slice is running.
    req = 4'b1111;
    repeat (7) cyc();
    #1 rst = 1'b1;
    #1;
    check("async_gnt", gnt, 4'b0000);
    check("async_led", led, 6'b111111);
    check("async_busy", busy, 1'b0);
    model_reset();
    #1 rst = 1'b0;
    repeat (2) cyc();
    check("first_after_rst", gnt, 4'b0001);

    // Random traffic.
    repeat (800) begin
      pattern = 24'($urandom);
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
